mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage that sits directly downstream of EX and upstream of WB.
- Registers the EX-to-MEM bus and the HI/LO write bundle.
- Selects the byte, halfword or word lane from the data SRAM read data (the read was issued in EX) and sign- or zero-extends it.
- Produces the MEM-to-WB bus plus a same-cycle forwarding bundle to ID.

Parameters:
- EX_TO_MEM_WD, 79: width of ex_to_mem_bus.
- MEM_TO_WB_WD, 70: width of mem_to_wb_bus.
- HILO_WD, 66: width of ex_hilo / mem_hilo.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  stall vector; bit3 = MEM stage, bit4 = WB stage; 1 = Stop.
- ex_to_mem_bus  in  79  layout {load_op[2:0], pc[31:0], data_ram_en, data_sram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}.
- ex_hilo  in  66  {hi_we, lo_we, hi_data[31:0], lo_data[31:0]}.
- data_sram_rdata  in  32  read data for the address issued in EX.
- mem_to_wb_bus  out  70  {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- mem_fwd  out  38  {rf_we, rf_waddr[4:0], rf_wdata[31:0]}, forwarding to ID.
- mem_hilo  out  66  registered ex_hilo, passed to WB.
- mem_is_load  out  1  MEM holds a load (data_ram_en & sel_rf_res); used by ID for the load-use check.

Behaviour:
- Pipeline register (ex_to_mem_bus_r, hilo_r), updated on posedge clk, priority order:
  1. rst: both cleared to 0.
  2. stall[3]=1 and stall[4]=0: both cleared to 0 (bubble into MEM).
  3. stall[3]=0: capture ex_to_mem_bus and ex_hilo.
  4. Otherwise: hold.
- All outputs are combinational from the registers and data_sram_rdata. After reset every output is 0, because the load path is masked when data_ram_en=0.
- Address offset: addr[1:0] = ex_result_r[1:0].
- load_op encoding and result:
  - 000 LW: rdata.
  - 001 LB: sign-extended byte at lane addr[1:0] (lane 0 = bits 7:0, lane 3 = bits 31:24; little-endian).
  - 010 LBU: same byte, zero-extended.
  - 011 LH: sign-extended halfword; addr[1]=0 selects bits 15:0, addr[1]=1 selects bits 31:16.
  - 100 LHU: same halfword, zero-extended.
  - 101..111: treated as LW.
- rf_wdata = sel_rf_res_r ? load_data : ex_result_r.
- load_data is forced to 0 when data_ram_en_r=0, so rdata never leaks.
- mem_to_wb_bus.rf_we = rf_we_r, gated by the optional feature below. mem_fwd carries the same rf_we, waddr and wdata as mem_to_wb_bus.
- Stores (data_sram_wen_r != 0) leave rf_we unchanged; EX drives rf_we=0 for stores.
- Latency: one cycle from the EX bus to the outputs. Load data is valid in the same cycle the instruction occupies MEM.
- Hold (stall[3]=1 and stall[4]=1): register unchanged. data_sram_rdata must be held stable by the SRAM (EX deasserts en for a bubble), so outputs stay stable.
- Bubble: a bubble never writes the RF or HI/LO, since all enables are 0.
- Reset mid-stall: reset wins and clears the register.
- rf_waddr=0 with rf_we=1 is passed unchanged; the regfile ignores writes to r0.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - Adds output mem_addr_err (1 bit), defined as data_ram_en_r & ((LW or SW-class access with addr[1:0]!=0) or (LH/LHU or half-store with addr[0]=1)).
  - Store width is derived from data_sram_wen_r popcount: 4 = word, 2 = half.
  - When mem_addr_err=1: rf_we on mem_to_wb_bus and mem_fwd is forced to 0, and mem_hilo enables are forced to 0.
  - Resets to 0.
- Undefined: no mem_addr_err port; misaligned accesses use the lane rules above without checking.

Test Plan:
- Reset: assert rst with ex_to_mem_bus all ones for 2 cycles -> every output 0, mem_is_load=0.
- LB sign-extension: load_op=001, addr=0x1003, sel_rf_res=1, rf_we=1, waddr=8, rdata=0x80FF_1234 -> rf_wdata=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH/LHU: addr=0x2002, rdata=0x9ABC_0000 -> LH gives 0xFFFF_9ABC, LHU gives 0x0000_9ABC. With addr=0x2000 and rdata=0x0000_7FFF, LH gives 0x0000_7FFF.
- ALU pass-through: sel_rf_res=0, data_ram_en=0, ex_result=0xDEAD_BEEF, rdata=0x1234_5678 -> rf_wdata=0xDEAD_BEEF, and mem_fwd matches mem_to_wb_bus.
- Stall and bubble:
  - stall=6'b001111 for 1 cycle -> next-cycle outputs all 0 (bubble).
  - stall=6'b011111 -> register held for 3 cycles; pc unchanged.
  - ex_hilo={1,1,0x1,0x2} captured only when stall[3]=0.
- MEM_ALIGN_CHK_EN: LW at 0x1001 with rf_we=1 -> mem_addr_err=1 and rf_we out=0. LH at 0x1002 -> mem_addr_err=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX->MEM->WB stage bundle: stall vector, EX bus, HI/LO, SRAM read data and stage outputs.
// Build with MEM_ALIGN_CHK_EN defined to add the mem_addr_err signal.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int HILO_WD      = 66
);
  logic [5:0]              stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [HILO_WD-1:0]      ex_hilo;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_fwd;
  logic [HILO_WD-1:0]      mem_hilo;
  logic                    mem_is_load;
`ifdef MEM_ALIGN_CHK_EN
  logic                    mem_addr_err;
`endif

  modport master (
    output stall, ex_to_mem_bus, ex_hilo, data_sram_rdata,
    input  mem_to_wb_bus, mem_fwd, mem_hilo, mem_is_load
`ifdef MEM_ALIGN_CHK_EN
    , input mem_addr_err
`endif
  );

  modport slave (
    input  stall, ex_to_mem_bus, ex_hilo, data_sram_rdata,
    output mem_to_wb_bus, mem_fwd, mem_hilo, mem_is_load
`ifdef MEM_ALIGN_CHK_EN
    , output mem_addr_err
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus and HI/LO bundle, extracts/extends load data.
// Optional MEM_ALIGN_CHK_EN adds misaligned-access detection that squashes RF/HI/LO writes.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int HILO_WD      = 66
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus_if
);

  logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
  logic [HILO_WD-1:0]      hilo_q, hilo_d;

  // MEM stalled while WB runs inserts a bubble; both stalled holds.
  always_comb begin
    bus_d  = bus_q;
    hilo_d = hilo_q;
    if (bus_if.stall[3] && !bus_if.stall[4]) begin
      bus_d  = '0;
      hilo_d = '0;
    end else if (!bus_if.stall[3]) begin
      bus_d  = bus_if.ex_to_mem_bus;
      hilo_d = bus_if.ex_hilo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q  <= '0;
      hilo_q <= '0;
    end else begin
      bus_q  <= bus_d;
      hilo_q <= hilo_d;
    end
  end

  logic [2:0]  load_op_q;
  logic [31:0] pc_q;
  logic        data_ram_en_q;
  logic [3:0]  data_sram_wen_q;
  logic        sel_rf_res_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] ex_result_q;
  logic [1:0]  addr_lo;

  assign load_op_q       = bus_q[78:76];
  assign pc_q            = bus_q[75:44];
  assign data_ram_en_q   = bus_q[43];
  assign data_sram_wen_q = bus_q[42:39];
  assign sel_rf_res_q    = bus_q[38];
  assign rf_we_q         = bus_q[37];
  assign rf_waddr_q      = bus_q[36:32];
  assign ex_result_q     = bus_q[31:0];
  assign addr_lo         = ex_result_q[1:0];

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  always_comb begin
    byte_lane = '0;
    case (addr_lo)
      2'd0:    byte_lane = bus_if.data_sram_rdata[7:0];
      2'd1:    byte_lane = bus_if.data_sram_rdata[15:8];
      2'd2:    byte_lane = bus_if.data_sram_rdata[23:16];
      default: byte_lane = bus_if.data_sram_rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? bus_if.data_sram_rdata[31:16] : bus_if.data_sram_rdata[15:0];

    load_data = '0;
    if (data_ram_en_q) begin
      case (load_op_q)
        3'b001:  load_data = {{24{byte_lane[7]}}, byte_lane};
        3'b010:  load_data = {24'd0, byte_lane};
        3'b011:  load_data = {{16{half_lane[15]}}, half_lane};
        3'b100:  load_data = {16'd0, half_lane};
        default: load_data = bus_if.data_sram_rdata;
      endcase
    end
  end

  logic addr_err;

`ifdef MEM_ALIGN_CHK_EN
  logic is_store, word_acc, half_acc;
  // Store width comes from the byte-enable count; load width from load_op.
  always_comb begin
    is_store = |data_sram_wen_q;
    if (is_store) begin
      word_acc = ($countones(data_sram_wen_q) == 4);
      half_acc = ($countones(data_sram_wen_q) == 2);
    end else begin
      half_acc = (load_op_q == 3'b011) || (load_op_q == 3'b100);
      word_acc = !half_acc && (load_op_q != 3'b001) && (load_op_q != 3'b010);
    end
    addr_err = data_ram_en_q &
               ((word_acc & (addr_lo != 2'b00)) | (half_acc & addr_lo[0]));
  end
  assign bus_if.mem_addr_err = addr_err;
`else
  assign addr_err = 1'b0;
`endif

  logic [31:0] rf_wdata;
  logic        rf_we_out;

  assign rf_wdata  = sel_rf_res_q ? load_data : ex_result_q;
  assign rf_we_out = rf_we_q & ~addr_err;

  assign bus_if.mem_to_wb_bus = {pc_q, rf_we_out, rf_waddr_q, rf_wdata};
  assign bus_if.mem_fwd       = {rf_we_out, rf_waddr_q, rf_wdata};
  assign bus_if.mem_hilo      = {hilo_q[65] & ~addr_err, hilo_q[64] & ~addr_err, hilo_q[63:0]};
  assign bus_if.mem_is_load   = data_ram_en_q & sel_rf_res_q;

  logic unused_bits;
  assign unused_bits = ^{bus_if.stall[5], bus_if.stall[2:0], data_sram_wen_q};

endmodule
